// File: rtl/agc_pkg.sv
// Shared AGC definitions: level word width and default detector sizing.
// Imported by the level detector and the error stage so the widths agree.
package agc_pkg;

    localparam int AGC_LEVEL_W  = 30;
    localparam int AGC_DIN_W    = 16;
    localparam int AGC_LOG2_WIN = 6;

    function automatic int agc_acc_w(input int din_w, input int log2_win);
        return 2 * din_w + log2_win;
    endfunction

endpackage

// File: rtl/agc_level_detector_if.sv
// Sample-in / level-out bundle between the AGC front end and the detector.
// master drives samples and consumes levels; slave is the detector side.
interface agc_level_detector_if
    import agc_pkg::*;
#(
    parameter int DIN_WIDTH = AGC_DIN_W,
    parameter int OUTWIDTH  = AGC_LEVEL_W
);

    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic [OUTWIDTH-1:0]         level_out;
    logic                        level_valid;

    modport master (
        output din,
        output din_valid,
        input  level_out,
        input  level_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output level_out,
        output level_valid
    );

endinterface

// File: rtl/agc_square.sv
// Registered input and registered square with valid pipeline.
// Isolated so the product maps onto one DSP multiplier.
module agc_square
    import agc_pkg::*;
#(
    parameter int DIN_WIDTH = AGC_DIN_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] din,
    input  logic                        din_valid,
    output logic [2*DIN_WIDTH-1:0]      sq,
    output logic                        sq_valid
);

    localparam int PW = 2 * DIN_WIDTH;

    logic signed [DIN_WIDTH-1:0] din_q, din_d;
    logic                        vld_q, vld_d;
    logic [PW-1:0]               sq_q, sq_d;
    logic                        sqv_q, sqv_d;
    logic signed [PW-1:0]        din_x;
    logic signed [PW-1:0]        prod;

    // Full-width signed product so (-2^(N-1))^2 is exact
    always_comb begin
        din_d = din;
        vld_d = din_valid;
        din_x = PW'(din_q);
        prod  = din_x * din_x;
        sq_d  = sq_q;
        sqv_d = vld_q;
        if (vld_q) begin
            sq_d = $unsigned(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            vld_q <= 1'b0;
            sq_q  <= '0;
            sqv_q <= 1'b0;
        end else begin
            din_q <= din_d;
            vld_q <= vld_d;
            sq_q  <= sq_d;
            sqv_q <= sqv_d;
        end
    end

    assign sq       = sq_q;
    assign sq_valid = sqv_q;

endmodule

// File: rtl/agc_level_detector.sv
// Mean-power detector: windowed average of squared samples, one level
// word per 2^LOG2_WIN valid samples, saturated to the positive range.
module agc_level_detector
    import agc_pkg::*;
#(
    parameter int DIN_WIDTH = AGC_DIN_W,
    parameter int LOG2_WIN  = AGC_LOG2_WIN,
    parameter int OUTWIDTH  = AGC_LEVEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    agc_level_detector_if.slave  bus
);

    localparam int PW    = 2 * DIN_WIDTH;
    localparam int SUM_W = agc_acc_w(DIN_WIDTH, LOG2_WIN);
    localparam int CW    = (SUM_W > OUTWIDTH) ? SUM_W : OUTWIDTH;

    localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;
    localparam logic [OUTWIDTH-1:0] LVL_MAX = {1'b0, {(OUTWIDTH-1){1'b1}}};

    logic [PW-1:0]       sq;
    logic                sq_valid;

    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                sumv_q, sumv_d;
    logic [OUTWIDTH-1:0] level_q, level_d;
    logic                lvlv_q, lvlv_d;
    logic [CW-1:0]       mean;

    agc_square #(
        .DIN_WIDTH (DIN_WIDTH)
    ) u_square (
        .clk       (clk),
        .rst       (rst),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .sq        (sq),
        .sq_valid  (sq_valid)
    );

    // Window end hands acc+sq onward and restarts with no sample dropped
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        sumv_d = 1'b0;
        if (sq_valid) begin
            if (cnt_q == CNT_MAX) begin
                sum_d  = acc_q + SUM_W'(sq);
                sumv_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = acc_q + SUM_W'(sq);
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mean    = CW'(sum_q >> LOG2_WIN);
        level_d = level_q;
        lvlv_d  = sumv_q;
        if (sumv_q) begin
            if (mean > CW'(LVL_MAX)) begin
                level_d = LVL_MAX;
            end else begin
                level_d = mean[OUTWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            sumv_q  <= 1'b0;
            level_q <= '0;
            lvlv_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sumv_q  <= sumv_d;
            level_q <= level_d;
            lvlv_q  <= lvlv_d;
        end
    end

    assign bus.level_out   = level_q;
    assign bus.level_valid = lvlv_q;

endmodule

// File: tb/tb_agc_level_detector.sv
// Bench for agc_level_detector: window-of-4 reference model feeding a
// scoreboard, with directed cases followed by randomized traffic.
module tb_agc_level_detector;

    localparam int DW   = 16;
    localparam int LW   = 2;
    localparam int OW   = 30;
    localparam int WIN  = 1 << LW;
    localparam longint LMAX = (longint'(1) << (OW - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    agc_level_detector_if #(.DIN_WIDTH(DW), .OUTWIDTH(OW)) bus ();

    agc_level_detector #(
        .DIN_WIDTH (DW),
        .LOG2_WIN  (LW),
        .OUTWIDTH  (OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     win[$];
    exp_t   e;
    int     cyc    = 0;
    int     checks = 0;
    int     fails  = 0;
    bit     prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mean of squares over each group of WIN accepted samples
    function automatic void model_sample(input int d);
        longint s;
        longint m;
        win.push_back(d);
        if (win.size() == WIN) begin
            s = 0;
            foreach (win[i]) s += longint'(win[i]) * longint'(win[i]);
            m = s / WIN;
            if (m > LMAX) m = LMAX;
            sb.push_back('{m, cyc + 4});
            win.delete();
        end
    endfunction

    task automatic drive(input bit r, input bit v, input int d);
        @(negedge clk);
        #1;
        rst           = r;
        bus.din       = DW'(d);
        bus.din_valid = v;
        if (r) begin
            sb.delete();
            win.delete();
        end else if (v) begin
            model_sample(d);
        end
    endtask

    function automatic int rand_d();
        case ($urandom_range(0, 3))
            0:       return -32768;
            1:       return 32767;
            2:       return int'($urandom_range(0, 200)) - 100;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bus.level_out !== '0 || bus.level_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_out: cyc=%0d level_out=%0d level_valid=%b, required 0/0",
                         cyc, bus.level_out, bus.level_valid);
            end
            prev_v = 1'b0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                fails++;
                $display("FAIL missing_strobe: no strobe at cyc=%0d, required level %0d",
                         sb[0].cyc, sb[0].val);
                void'(sb.pop_front());
            end
            if (bus.level_valid === 1'b1) begin
                checks++;
                if (prev_v) begin
                    fails++;
                    $display("FAIL double_strobe: level_valid high on consecutive cycles at cyc=%0d", cyc);
                end
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: cyc=%0d level_out=%0d, required no strobe",
                             cyc, bus.level_out);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || longint'(bus.level_out) != e.val) begin
                        fails++;
                        $display("FAIL level: got %0d at cyc=%0d, required %0d at cyc=%0d",
                                 bus.level_out, cyc, e.val, e.cyc);
                    end
                end
            end
            prev_v = (bus.level_valid === 1'b1);
        end
    end

    initial begin
        int r;
        bus.din       = '0;
        bus.din_valid = 1'b0;

        // din_valid during reset must be ignored
        repeat (3) drive(1'b1, 1'b1, 5);

        repeat (12) drive(1'b0, 1'b1, 100);

        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, i);

        for (int i = 0; i < 24; i++)
            drive(1'b0, (i % 3) == 0, (i % 2 == 0) ? 1000 : -1000);

        repeat (4) drive(1'b0, 1'b1, -32768);

        repeat (4) drive(1'b0, 1'b1, 10);
        repeat (4) drive(1'b0, 1'b1, 20);

        repeat (3) drive(1'b0, 1'b1, 50);
        drive(1'b1, 1'b1, 50);
        repeat (4) drive(1'b0, 1'b1, 7);
        repeat (2) drive(1'b0, 1'b0, 0);

        repeat (500) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) drive(1'b1, 1'($urandom_range(0, 1)), rand_d());
            else       drive(1'b0, r < 70, rand_d());
        end

        repeat (8) drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) drive(1'b0, 1'b0, 0);
        while (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: strobe for level %0d never arrived", sb[0].val);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/agc_level_detector.md
# agc_level_detector

Mean-power detector that feeds the AGC error integrator. It squares each valid input sample and averages the squares over a fixed window of 2^LOG2_WIN samples. Once per window it emits one non-negative level word, which drives the error stage's data input, together with a one-cycle valid strobe that drives that stage's valid input.

## Interface

**Parameters**
- DIN_WIDTH, 16: signed input sample width.
- LOG2_WIN, 6: log2 of window length in valid samples (window = 64); legal range 1..12.
- OUTWIDTH, 30: level word width; matches the error stage's data width (signed, so only positive range is used).

**Ports**
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DIN_WIDTH  signed sample, two's complement.
- din_valid  input  1  din qualifier; may be deasserted for any number of cycles.
- level_out  output  OUTWIDTH  mean power of last completed window, unsigned value in a signed container.
- level_valid  output  1  one-cycle strobe, level_out updated this cycle.

## Operation

- Stage 1: register din and din_valid.
- Stage 2: sq = din*din, signed × signed, held in 2*DIN_WIDTH bits and treated as unsigned. The square of -2^(DIN_WIDTH-1) must be representable. Valid is carried alongside.
- Stage 3, accumulate:
  - acc width: 2*DIN_WIDTH+LOG2_WIN bits, so it never overflows.
  - cnt width: LOG2_WIN bits, counting valid squares.
  - On a valid square with cnt != 2^LOG2_WIN-1: acc += sq, cnt += 1.
  - On the valid square with cnt == 2^LOG2_WIN-1 (window end): sum = acc+sq is passed to stage 4, acc loads 0, cnt wraps to 0.
  - Back-to-back windows lose no sample.
  - Invalid cycles leave acc and cnt unchanged.
- Stage 4, output:
  - mean = sum >> LOG2_WIN (truncation, no rounding).
  - If mean > 2^(OUTWIDTH-1)-1, level_out = 2^(OUTWIDTH-1)-1 (saturate); else level_out = mean zero-extended.
  - level_valid = 1 for exactly that cycle.
- level_out holds its value between strobes.
- Reset clears all pipeline registers, valids, acc, cnt, level_out (0) and level_valid (0).
  - Reset mid-window discards the partial window and any in-flight samples.
  - The first window after reset starts with the first valid sample following rst deassertion.
  - din_valid asserted in the same cycle as rst is ignored.

## Timing

- Window-end sample accepted (din_valid=1) at edge E → level_out/level_valid update at edge E+3. Fixed latency, independent of din_valid gaps.
- Throughput: one sample per clock.
- Minimum spacing of level_valid strobes: 2^LOG2_WIN cycles.
- level_valid is never high for two consecutive cycles unless LOG2_WIN would allow it; with LOG2_WIN ≥ 1 it never is.
- Reset values: level_out = 0, level_valid = 0, also during the cycles that rst is held.
- No backpressure: the downstream stage must accept every strobe.

## Structure

- Shared package agc_pkg:
  - AGC_LEVEL_W = 30.
  - Default DIN_WIDTH and LOG2_WIN.
  - A localparam function for the acc width (2*DIN_WIDTH+LOG2_WIN).
  - Used by this block and the error stage so the level width stays consistent.
- One sub-module, agc_square:
  - Stages 1–2: registered input, registered square, valid pipeline.
  - Kept separate so it maps cleanly onto a single DSP multiplier.
- Accumulate/window/saturate logic stays in the top.

## Test plan

All with LOG2_WIN=2 (window 4), DIN_WIDTH=16, OUTWIDTH=30 unless stated.

- Constant din=100, din_valid=1 continuous → level_out=10000 every 4th cycle; first strobe 3 edges after 4th sample.
- Samples 1,2,3,4 → sum 30, level_out=7 (truncation).
- din alternating +1000/-1000 with din_valid toggling 1,0,0,1,… → level_out=1000000; strobe timing tracks the 4th valid sample + 3.
- din=-32768 constant → mean 2^30 saturates, level_out=536870911.
- Full-window samples differ: window A=10 ×4, window B=20 ×4, back-to-back → 100 then 400; no cross-window mixing.
- Send 3 samples of 50, assert rst 1 cycle, then 4 samples of 7 → outputs 0/level_valid 0 during reset; first strobe level_out=49, strobe time set by the 4th post-reset sample.
